// File: rtl/activation_backprop.sv
// Backward pass of the clamp-sigmoid neuron: computes the gradient, then walks
// the weight memory applying w_i += ETA*delta*in_i in 17.15 fixed point.
module activation_backprop #(
    parameter int unsigned        N_INPUTS = 4,
    parameter int unsigned        ADDR_W   = 2,
    parameter logic signed [31:0] ETA      = 32'sd3277
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [31:0]       x,
    input  logic signed [31:0]       target,
    output logic                     busy,
    output logic                     done,
    output logic signed [31:0]       delta,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic signed [31:0]       in_rd_data,
    input  logic signed [31:0]       w_rd_data,
    output logic                     w_wr_en,
    output logic signed [31:0]       w_wr_data
);

    localparam int unsigned DW   = 32;
    localparam int unsigned PW   = 64;
    localparam int unsigned FRAC = 15;
    localparam logic signed [DW-1:0] ONE   = 32'sd32768;
    localparam logic signed [DW-1:0] ZERO  = 32'sd0;
    localparam logic signed [DW-1:0] MAX32 = 32'sh7FFFFFFF;
    localparam logic signed [DW-1:0] MIN32 = 32'sh80000000;
    localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(N_INPUTS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_GRAD, S_SCALE, S_READ, S_WRITE, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic signed [DW-1:0] x_q, x_d, target_q, target_d;
    logic signed [DW-1:0] delta_q, delta_d, g_q, g_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic                 busy_q, busy_d, done_q, done_d, w_wr_en_q, w_wr_en_d;

    logic signed [DW-1:0] y_c, err_c, g_next_c, dw_c, wr_sum_c;
    logic                 fprime_c;

    function automatic logic signed [DW-1:0] sat32(input logic signed [PW-1:0] v);
        if (v > PW'(MAX32))      sat32 = MAX32;
        else if (v < PW'(MIN32)) sat32 = MIN32;
        else                     sat32 = v[DW-1:0];
    endfunction

    // Arithmetic is done at 64 bits and clamped so no intermediate can wrap.
    always_comb begin
        y_c = x_q;
        if (x_q < ZERO)     y_c = ZERO;
        else if (x_q > ONE) y_c = ONE;
        fprime_c = (x_q >= ZERO) && (x_q <= ONE);
        err_c    = sat32(PW'(target_q) - PW'(y_c));
        g_next_c = sat32((PW'(ETA) * PW'(delta_q)) >>> FRAC);
        dw_c     = sat32((PW'(g_q) * PW'(in_rd_data)) >>> FRAC);
        wr_sum_c = sat32(PW'(w_rd_data) + PW'(dw_c));
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_GRAD;
            S_GRAD:  state_d = S_SCALE;
            S_SCALE: state_d = (delta_q == ZERO) ? S_DONE : S_READ;
            S_READ:  state_d = S_WRITE;
            S_WRITE: state_d = (mem_addr_q == LAST_ADDR) ? S_DONE : S_READ;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers and state-aligned registered strobes.
    always_comb begin
        x_d        = x_q;
        target_d   = target_q;
        delta_d    = delta_q;
        g_d        = g_q;
        mem_addr_d = mem_addr_q;
        unique case (state_q)
            S_IDLE: if (start) begin
                x_d      = x;
                target_d = target;
            end
            S_GRAD:  delta_d = fprime_c ? err_c : ZERO;
            S_SCALE: begin
                g_d        = g_next_c;
                mem_addr_d = '0;
            end
            S_WRITE: if (mem_addr_q != LAST_ADDR) mem_addr_d = mem_addr_q + ADDR_W'(1);
            default: ;
        endcase
        busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d    = (state_d == S_DONE);
        w_wr_en_d = (state_d == S_WRITE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q        <= '0;
            target_q   <= '0;
            delta_q    <= '0;
            g_q        <= '0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            w_wr_en_q  <= 1'b0;
        end else begin
            x_q        <= x_d;
            target_q   <= target_d;
            delta_q    <= delta_d;
            g_q        <= g_d;
            mem_addr_q <= mem_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            w_wr_en_q  <= w_wr_en_d;
        end
    end

    // Read data lands during WRITE, so the new weight is formed in that cycle;
    // reset suppresses the strobe immediately so an aborted pair never writes.
    assign busy      = busy_q;
    assign done      = done_q;
    assign delta     = delta_q;
    assign mem_addr  = mem_addr_q;
    assign w_wr_en   = w_wr_en_q & ~rst;
    assign w_wr_data = w_wr_en ? wr_sum_c : '0;

endmodule

// File: doc/activation_backprop.md
Name: activation_backprop

Overview:
- Training-direction counterpart of the clamp-sigmoid activation in the single-layer perceptron.
- Given a neuron's pre-activation x and a target, it:
  - recomputes the clamped output y;
  - forms the error gradient through the activation derivative;
  - walks the neuron's weight memory, applying w_i += ETA*delta*in_i.
- Sits beside the forward datapath and shares the input/weight RAM port via the address/write interface below.
- All values are signed 32-bit, 17.15 fixed point (ONE = 32768).

Parameters:
- N_INPUTS, 4, number of input/weight pairs per neuron (>=1).
- ADDR_W, 2, address width; 2**ADDR_W >= N_INPUTS.
- ETA, 32'sd3277, learning rate in 17.15 (≈0.1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request update; sampled only in IDLE.
- x  in  32  signed pre-activation; captured on accepted start.
- target  in  32  signed desired output; captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the update completes.
- delta  out  32  registered gradient of the last update; holds until the next start.
- mem_addr  out  ADDR_W  address into the input and weight memories.
- in_rd_data  in  32  input value; valid one cycle after mem_addr (synchronous read).
- w_rd_data  in  32  weight value; valid one cycle after mem_addr.
- w_wr_en  out  1  weight write strobe.
- w_wr_data  out  32  new weight, written at mem_addr.

Behaviour:
- Reset values: all outputs 0 (busy, done, delta, mem_addr, w_wr_en, w_wr_data). FSM returns to IDLE.
- Reset mid-operation: abort at the next edge, with no further writes. Weights already written stay written.
- FSM states: IDLE, GRAD, SCALE, READ, WRITE, DONE.
- IDLE: on start=1, register x and target, go to GRAD. start in any other state is ignored (not queued).
- GRAD (1 cycle):
  - y = 0 if x<0; ONE if x>ONE; else x.
  - Derivative f' = 1 iff 0<=x<=ONE (both bounds inclusive), else 0.
  - err = target − y, saturated to signed 32.
  - delta <= f' ? err : 0.
- SCALE (1 cycle):
  - g = (ETA*delta) computed at 64 bits, arithmetic shift right by 15 (floor), saturated to 32 bits.
  - If delta==0, go directly to DONE (no memory traffic). Otherwise set mem_addr=0 and go to READ.
- READ (1 cycle): mem_addr holds index i; read data returns next cycle.
- WRITE (1 cycle):
  - dw = sat32((g*in_rd_data)>>>15).
  - w_wr_data = sat32(w_rd_data + dw), with w_wr_en=1 at the same mem_addr.
  - If i==N_INPUTS−1, go to DONE. Else mem_addr = i+1 and go to READ.
- Write ordering: w_wr_en is high only in WRITE; exactly N_INPUTS writes per non-zero update, in ascending address order.
- DONE (1 cycle): done=1, busy=0 on the same cycle, then IDLE. A start is accepted no earlier than the following cycle.
- Latency, with start accepted at edge 0:
  - delta valid after edge 2.
  - done at cycle 3+2*N_INPUTS (non-zero delta), or cycle 3 (zero delta).
- Saturation: clamp to 32'h7FFFFFFF / 32'h80000000. No wrap-around permitted on any intermediate.
- mem_addr is held stable throughout each READ/WRITE pair.

Test Plan:
- x=16384, target=32768, in[i]=32768, w[i]=0 →
  - delta=16384, g=1638;
  - four writes of 1638 at addrs 0..3 in cycles 4,6,8,10;
  - done at cycle 11.
- x=32768 (=ONE boundary), target=0, in=32768, w=0 → delta=−32768, every w written −3277 (derivative inclusive at ONE).
- x=−1 and separately x=32769, target=32768 → delta=0, w_wr_en never asserted, done at cycle 3.
- w=32'h7FFFFFF0, x=0, target=32'h7FFFFFFF, in=32'h7FFFFFFF → every write 32'h7FFFFFFF (saturation, no wrap).
- Pulse start again during busy → ignored: exactly N writes, a single done pulse.
- Assert rst during the second WRITE → from the next cycle busy=0, done=0, w_wr_en=0. w[0] keeps its updated value, w[1..3] are unchanged, and a following start runs a full update normally.
